// File: rtl/risc_toy_ifetch_queue.sv
// Instruction prefetch queue: sequential fetch ahead of decode, redirect flush.
// Optional performance counters are built when IFQ_PERF_EN is defined.
module risc_toy_ifetch_queue #(
  parameter int unsigned   DEPTH    = 4,
  parameter int unsigned   AW       = 30,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          CLK,
  input  logic          RSTN,
  output logic          IREQ,
  output logic [AW-1:0] IADDR,
  input  logic [31:0]   INSTR,
  input  logic          REDIR,
  input  logic [AW-1:0] REDIR_ADDR,
  output logic          D_VALID,
  input  logic          D_READY,
  output logic [31:0]   D_INSTR,
  output logic [AW-1:0] D_PC,
  output logic [31:0]   PERF_FETCH,
  output logic [15:0]   PERF_FLUSH
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   instr_mem_q [DEPTH];
  logic [AW-1:0] pc_mem_q    [DEPTH];

  logic [AW-1:0] fetch_pc_q,    fetch_pc_d;
  logic [AW-1:0] inflight_pc_q, inflight_pc_d;
  logic          inflight_v_q,  inflight_v_d;
  logic [PW-1:0] head_q,        head_d;
  logic [PW-1:0] tail_q,        tail_d;
  logic [CW-1:0] count_q,       count_d;

  logic          issue_c;
  logic          push_c;
  logic          pop_c;
  logic          dvalid_c;
  logic [CW:0]   occ_c;

  // Issue, push and pop decisions plus next-state; redirect overrides all
  always_comb begin
    occ_c         = {1'b0, count_q} + (CW+1)'(inflight_v_q);
    issue_c       = RSTN && !REDIR && (occ_c < (CW+1)'(DEPTH));
    push_c        = inflight_v_q && !REDIR;
    dvalid_c      = (count_q != '0) && !REDIR;
    pop_c         = dvalid_c && D_READY;

    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_v_d  = issue_c;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;

    if (REDIR) begin
      fetch_pc_d   = REDIR_ADDR;
      inflight_v_d = 1'b0;
      head_d       = tail_q;
      count_d      = '0;
    end else begin
      if (issue_c) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + AW'(1);
      end
      if (push_c) tail_d = tail_q + PW'(1);
      if (pop_c)  head_d = head_q + PW'(1);
      count_d = count_q + CW'(push_c) - CW'(pop_c);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_v_q  <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_v_q  <= inflight_v_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  // Entry storage; cleared on reset so the head reads zero until written
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push_c) begin
      instr_mem_q[tail_q] <= INSTR;
      pc_mem_q[tail_q]    <= inflight_pc_q;
    end
  end

  assign IREQ    = issue_c;
  assign IADDR   = fetch_pc_q;
  assign D_VALID = dvalid_c;
  assign D_INSTR = instr_mem_q[head_q];
  assign D_PC    = pc_mem_q[head_q];

`ifdef IFQ_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [15:0] perf_flush_q;

  // Saturating delivery and redirect counters
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (pop_c && (perf_fetch_q != '1)) perf_fetch_q <= perf_fetch_q + 32'(1);
      if (REDIR && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + 16'(1);
    end
  end

  assign PERF_FETCH = perf_fetch_q;
  assign PERF_FLUSH = perf_flush_q;
`else
  assign PERF_FETCH = '0;
  assign PERF_FLUSH = '0;
`endif

  a_count_bound: assert property (@(posedge CLK) disable iff (!RSTN) count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_risc_toy_ifetch_queue.sv
// Bench for risc_toy_ifetch_queue: queue-based reference model, directed and random stimulus.
module tb_risc_toy_ifetch_queue;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        IREQ;
  logic [29:0] IADDR;
  logic [31:0] INSTR;
  logic        REDIR = 1'b0;
  logic [29:0] REDIR_ADDR = '0;
  logic        D_VALID;
  logic        D_READY = 1'b1;
  logic [31:0] D_INSTR;
  logic [29:0] D_PC;
  logic [31:0] PERF_FETCH;
  logic [15:0] PERF_FLUSH;

  int checks = 0;
  int failures = 0;

  risc_toy_ifetch_queue #(.DEPTH(DEPTH), .AW(30), .RESET_PC(30'h0)) dut (
    .CLK(CLK), .RSTN(RSTN), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
    .REDIR(REDIR), .REDIR_ADDR(REDIR_ADDR), .D_VALID(D_VALID), .D_READY(D_READY),
    .D_INSTR(D_INSTR), .D_PC(D_PC), .PERF_FETCH(PERF_FETCH), .PERF_FLUSH(PERF_FLUSH)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] instr_of(logic [29:0] a);
    return 32'(a) + 32'h1000;
  endfunction

  // Synchronous memory with 1-cycle latency; garbage when no read was issued
  logic        mem_v = 1'b0;
  logic [29:0] mem_addr = '0;
  logic [31:0] junk = 32'hDEAD_BEEF;
  always @(posedge CLK) begin
    mem_v    <= IREQ;
    mem_addr <= IADDR;
    junk     <= $urandom;
  end
  assign INSTR = mem_v ? instr_of(mem_addr) : junk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetched-word queue plus fetch cursor and one outstanding read
  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [29:0] m_fetch_pc = '0;
  bit          m_inf = 1'b0;
  logic [29:0] m_inf_pc = '0;
  int          m_nfetch = 0;
  int          m_nflush = 0;

  always @(negedge CLK) begin
    bit   e_ireq, e_dv;
    ent_t e;
    if (!RSTN) begin
      chk("rst_ireq", IREQ, 0);
      chk("rst_dvalid", D_VALID, 0);
      chk("rst_dpc", D_PC, 0);
      chk("rst_dinstr", D_INSTR, 0);
      chk("rst_perf_fetch", PERF_FETCH, 0);
      chk("rst_perf_flush", PERF_FLUSH, 0);
      mq.delete();
      m_fetch_pc = '0;
      m_inf      = 1'b0;
      m_nfetch   = 0;
      m_nflush   = 0;
    end else begin
      e_ireq = !REDIR && ((mq.size() + int'(m_inf)) < DEPTH);
      e_dv   = (mq.size() != 0) && !REDIR;
      chk("ireq", IREQ, e_ireq);
      chk("iaddr", IADDR, m_fetch_pc);
      chk("dvalid", D_VALID, e_dv);
      if (e_dv) begin
        chk("dpc", D_PC, mq[0].pc);
        chk("dinstr", D_INSTR, mq[0].ins);
      end
`ifdef IFQ_PERF_EN
      chk("perf_fetch", PERF_FETCH, m_nfetch);
      chk("perf_flush", PERF_FLUSH, m_nflush);
`else
      chk("perf_fetch", PERF_FETCH, 0);
      chk("perf_flush", PERF_FLUSH, 0);
`endif
      if (REDIR) begin
        mq.delete();
        m_inf      = 1'b0;
        m_fetch_pc = REDIR_ADDR;
        m_nflush++;
      end else begin
        if (e_dv && D_READY) begin
          void'(mq.pop_front());
          m_nfetch++;
        end
        if (m_inf) begin
          e.pc  = m_inf_pc;
          e.ins = instr_of(m_inf_pc);
          mq.push_back(e);
        end
        m_inf = e_ireq;
        if (e_ireq) begin
          m_inf_pc   = m_fetch_pc;
          m_fetch_pc = m_fetch_pc + 30'd1;
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(int n);
    RSTN  = 1'b0;
    REDIR = 1'b0;
    repeat (n) step();
    RSTN = 1'b1;
  endtask

  task automatic wait_dv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (D_VALID) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit          ok;
    int          n;
    int          r;
    logic [29:0] wrap_pc [4];
    wrap_pc = '{30'h3FFFFFFE, 30'h3FFFFFFF, 30'h0, 30'h1};

    // Streaming from reset
    D_READY = 1'b1;
    do_reset(3);
    @(negedge CLK);
    chk("s1_first_ireq", IREQ, 1);
    chk("s1_iaddr0", IADDR, 0);
    chk("s1_no_dvalid0", D_VALID, 0);
    @(negedge CLK);
    chk("s1_iaddr1", IADDR, 1);
    chk("s1_no_dvalid1", D_VALID, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("s1_dvalid", D_VALID, 1);
      chk("s1_dpc", D_PC, k);
      chk("s1_dinstr", D_INSTR, 32'h1000 + k);
      chk("s1_iaddr", IADDR, 2 + k);
    end
    step();

    // Fill with decode stalled, then drain
    D_READY = 1'b0;
    do_reset(2);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (IREQ) begin
        chk("s2_iaddr", IADDR, n);
        n++;
      end
      if (D_VALID) chk("s2_hold_dpc", D_PC, 0);
    end
    chk("s2_ireq_count", n, 4);
    step();
    D_READY = 1'b1;
    @(negedge CLK);
    chk("s2_drain_dpc0", D_PC, 0);
    chk("s2_no_credit", IREQ, 0);
    for (int k = 1; k < 4; k++) begin
      @(negedge CLK);
      chk("s2_drain_dpc", D_PC, k);
      if (k == 1) begin
        chk("s2_resume_ireq", IREQ, 1);
        chk("s2_resume_iaddr", IADDR, 4);
      end
    end
    step();

    // Redirect with three queued and one in flight
    D_READY = 1'b0;
    do_reset(2);
    repeat (4) step();
    REDIR = 1'b1;
    REDIR_ADDR = 30'h100;
    D_READY = 1'b1;
    @(negedge CLK);
    chk("s3_redir_dvalid", D_VALID, 0);
    chk("s3_redir_ireq", IREQ, 0);
    step();
    REDIR = 1'b0;
    @(negedge CLK);
    chk("s3_ireq", IREQ, 1);
    chk("s3_iaddr", IADDR, 30'h100);
    @(negedge CLK);
    chk("s3_t2_dvalid", D_VALID, 0);
    @(negedge CLK);
    chk("s3_t3_dvalid", D_VALID, 1);
    chk("s3_t3_dpc", D_PC, 30'h100);
    step();

    // Back-to-back redirects: last target wins
    REDIR = 1'b1;
    REDIR_ADDR = 30'h20;
    @(negedge CLK);
    chk("s4_ireq_a", IREQ, 0);
    step();
    REDIR_ADDR = 30'h40;
    @(negedge CLK);
    chk("s4_ireq_b", IREQ, 0);
    step();
    REDIR = 1'b0;
    @(negedge CLK);
    chk("s4_ireq", IREQ, 1);
    chk("s4_iaddr", IADDR, 30'h40);
    wait_dv(ok);
    chk("s4_dvalid_seen", ok, 1);
    chk("s4_first_dpc", D_PC, 30'h40);
    step();

    // Address wrap
    REDIR = 1'b1;
    REDIR_ADDR = 30'h3FFFFFFE;
    step();
    REDIR = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_dv(ok);
      chk("s5_dvalid_seen", ok, 1);
      chk("s5_wrap_dpc", D_PC, wrap_pc[k]);
    end
    step();

    // Counters: three redirects then ten deliveries
    do_reset(2);
    D_READY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      REDIR = 1'b1;
      REDIR_ADDR = 30'h50 + 30'(k * 16);
      step();
      REDIR = 1'b0;
      step();
    end
    n = 0;
    for (int i = 0; i < 40 && n < 10; i++) begin
      @(negedge CLK);
      if (D_VALID) n++;
    end
    chk("s6_deliveries", n, 10);
    step();
    D_READY = 1'b0;
    @(negedge CLK);
`ifdef IFQ_PERF_EN
    chk("s6_perf_fetch", PERF_FETCH, 10);
    chk("s6_perf_flush", PERF_FLUSH, 3);
`else
    chk("s6_perf_fetch", PERF_FETCH, 0);
    chk("s6_perf_flush", PERF_FLUSH, 0);
`endif
    step();

    // Random traffic with redirects and occasional mid-run resets
    for (int i = 0; i < 3000; i++) begin
      r          = int'($urandom_range(0, 99));
      D_READY    = ($urandom_range(0, 9) < 7);
      REDIR      = (r < 5);
      REDIR_ADDR = ($urandom_range(0, 3) == 0) ? 30'h3FFFFFFC + 30'($urandom_range(0, 3))
                                               : 30'($urandom);
      RSTN       = (r < 98);
      step();
    end
    RSTN  = 1'b1;
    REDIR = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/risc_toy_ifetch_queue.md
Name: risc_toy_ifetch_queue

Overview:
Instruction prefetch queue between the RISC_TOY instruction memory port and the core's decode stage. It runs ahead of decode, issuing sequential word fetches to a synchronous instruction memory with 1-cycle read latency. It buffers fetched words with their PCs in a small FIFO and hands them downstream over a valid/ready handshake. On a branch or jump redirect it discards all buffered and in-flight fetches and restarts at the new word address.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
AW, 30, instruction word-address width
RESET_PC, 0, word address fetched first after reset

Ports:
CLK  input  1  clock, rising edge
RSTN  input  1  asynchronous active-low reset
IREQ  output  1  fetch request to instruction memory this cycle
IADDR  output  AW  word address of the fetch; equals fetch_pc at all times
INSTR  input  32  memory read data; valid the cycle after an IREQ cycle
REDIR  input  1  redirect pulse from execute (taken BR/BRL/J/JL)
REDIR_ADDR  input  AW  redirect target word address
D_VALID  output  1  head entry valid toward decode
D_READY  input  1  decode accepts head this cycle
D_INSTR  output  32  head instruction word
D_PC  output  AW  head instruction word address
PERF_FETCH  output  32  delivered-instruction counter (optional feature)
PERF_FLUSH  output  16  redirect counter (optional feature)

Behaviour:
- Reset is RSTN, asynchronous, active-low; clock is CLK. During reset: fetch_pc=RESET_PC, count=0, head/tail pointers=0, inflight_v=0. IREQ=0 and D_VALID=0 while RSTN is low. D_INSTR and D_PC reset to 0.
- State: FIFO of DEPTH x {instr[31:0], pc[AW-1:0]}, occupancy count (0..DEPTH), inflight_v flag, inflight_pc register.
- Issue: IREQ = !REDIR && (count + inflight_v < DEPTH), where count is the value at the start of the cycle. A pop in the same cycle is not credited. On issue: inflight_v<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1 modulo 2^AW (wraps from all-ones to 0). Without issue: inflight_v<=0.
- Response: when inflight_v=1 and REDIR=0, the block writes {INSTR, inflight_pc} at tail in that cycle and advances tail.
- Delivery: D_VALID = (count!=0) && !REDIR. D_INSTR and D_PC come from the head combinationally. When D_VALID && D_READY, head advances.
- Simultaneous push and pop leaves count unchanged. Pop on empty cannot occur. The issue rule makes overflow impossible; an assertion must check count<=DEPTH.
- Redirect has priority over everything in that cycle. count<=0, head<=tail, inflight_v<=0, and any response arriving in this cycle or the next is discarded. fetch_pc<=REDIR_ADDR. No pop is accepted.
- Latency: redirect at cycle t -> IREQ with IADDR=REDIR_ADDR at t+1 -> INSTR at t+2 -> D_VALID with D_PC=REDIR_ADDR at t+3. On an empty queue, 2 cycles from IREQ to D_VALID.
- Steady state with D_READY=1: one instruction per cycle once filled.
- Back-to-back REDIR in consecutive cycles: the last target wins, with no fetch from earlier targets delivered.
- Reset asserted mid-operation clears all state immediately; the pending memory response is ignored.

Optional Feature:
Macro IFQ_PERF_EN.
- Defined: PERF_FETCH increments on each D_VALID&&D_READY and saturates at 32'hFFFFFFFF. PERF_FLUSH increments on each REDIR cycle and saturates at 16'hFFFF. Both reset to 0.
- Undefined: no counter registers are built; PERF_FETCH and PERF_FLUSH are tied to 0. Ports are identical in both builds.

Test Plan:
- Reset release, D_READY=1, memory returns INSTR=IADDR+32'h1000 -> IREQ at the first cycle after reset with IADDR=0,1,2...; D_VALID 2 cycles after the first IREQ; D_PC=0,1,2 with D_INSTR=32'h1000,32'h1001,32'h1002, one per cycle.
- D_READY=0 from reset -> exactly 4 IREQs (IADDR 0..3); IREQ then stays 0; D_PC stays 0. Raising D_READY drains 0..3 in order, and fetching resumes at IADDR=4.
- Steady stream, REDIR=1 with REDIR_ADDR=30'h100 while the queue holds 3 entries plus 1 in flight -> D_VALID=0 that cycle; the next IREQ has IADDR=30'h100; the next delivered D_PC is 30'h100, with none of the old entries.
- REDIR two consecutive cycles (targets 30'h20, then 30'h40) -> first delivered D_PC=30'h40; 30'h20 is never issued.
- fetch_pc=30'h3FFFFFFE streaming -> D_PC sequence 30'h3FFFFFFE, 30'h3FFFFFFF, 0, 1.
- IFQ_PERF_EN defined: 10 deliveries and 3 redirects -> PERF_FETCH=10, PERF_FLUSH=3. Undefined: both read 0.
